tipi_pi_bus_master: RTL and testbench
=====================================

Name: tipi_pi_bus_master

Overview:
- MCU-side sequencer for the TIPI 4-bit nibble bus.
- Generates the bus clock and bus reset for the CPLD-side nibble port.
- Arbitrates four local requesters: write RD, write RC, read TD, read TC.
- Runs each request as one 4-clock bus transaction: select nibble, high nibble, low nibble, tail.

Parameters:
- CLK_DIV, 4: sys clocks per pi_clk half-period; legal range 1..255.
- RESET_CYCLES, 2: pi_clk periods for which pi_reset is held after reset; minimum 1.
- POLL_INTERVAL, 1024: idle sys clocks between automatic TC reads (AUTO_POLL_EN only).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- pi_clk  out  1  bus clock to the nibble port.
- pi_reset  out  1  bus reset to the nibble port.
- pi_data_o  out  4  nibble driven by the master.
- pi_data_oe  out  1  1 = master drives pi_data_o onto the bus.
- pi_data_i  in  4  nibble sampled from the bus.
- wrd_req  in  1  request to write RD.
- wrd_data  in  8  RD write value.
- wrd_ack  out  1  RD write done.
- wrc_req  in  1  request to write RC.
- wrc_data  in  8  RC write value.
- wrc_ack  out  1  RC write done.
- rtd_req  in  1  request to read TD.
- rtd_ack  out  1  TD read done.
- rtc_req  in  1  request to read TC.
- rtc_ack  out  1  TC read done.
- rd_data  out  8  read result.
- busy  out  1  1 while any transaction or bus reset is in progress.
- tc_poll  out  8  last auto-polled TC value.
- tc_change  out  1  1-cycle pulse when an auto-polled TC differs from tc_poll.

Behaviour:
- Clocking and reset:
  - One clock (clk). Synchronous active-high reset.
  - Reset values: pi_clk=0, pi_reset=1, pi_data_o=0, pi_data_oe=0, all acks=0, rd_data=0, busy=1, tc_poll=0, tc_change=0.
- Bus period:
  - Each bus period is 2*CLK_DIV sys clocks: pi_clk low for CLK_DIV, then high for CLK_DIV.
  - pi_data_o and pi_data_oe update on the first sys cycle of the low phase.
  - pi_data_i is sampled on the last sys cycle of the low phase, i.e. just before the pi_clk rising edge.
- FSM states: BUS_RST, IDLE, SEL, NIB_HI, NIB_LO, TAIL.
  - BUS_RST: pi_reset=1 and pi_clk toggling for RESET_CYCLES periods. Then pi_reset=0, go to IDLE. This realigns the slave nibble counter.
  - IDLE: pi_clk=0, busy=0. When any request is present, grant one on the next clk edge and go to SEL. Write data is captured at grant.
  - SEL: pi_data_oe=1, pi_data_o={2'b00, sel}. sel codes: TD=00, TC=01, RD=10, RC=11.
  - NIB_HI:
    - Write: oe=1, drive data[7:4].
    - Read: oe=0, sample into rd_data[7:4].
  - NIB_LO: same as NIB_HI using bits [3:0].
  - TAIL: oe=0, one dummy period that completes the slave's 4-count. Then return to IDLE.
- Completion:
  - The cycle after TAIL ends, the granted requester's ack pulses for 1 cycle.
  - For reads, rd_data is valid from that cycle and holds until the next read completes.
  - Grant-to-ack latency = 8*CLK_DIV + 1 clk.
- Priority: fixed, wrc > wrd > rtc > rtd (> auto-poll).
  - Arbitration happens only in IDLE. Requests arriving mid-transaction wait.
- Request handshake:
  - Requests are level-sensitive; the requester holds req until ack.
  - If req is dropped before ack, the transaction still completes and ack is still pulsed.
  - A req still high in the cycle of its ack is treated as a new request.
  - Back-to-back requests: IDLE lasts exactly 1 clk between transactions.
- Reset mid-transaction: abort immediately, no ack, enter BUS_RST.

Optional Feature:
- Macro: TIPI_PI_AUTO_POLL_EN.
- Defined:
  - An idle counter runs while in IDLE with no request pending. It resets on leaving IDLE.
  - On reaching POLL_INTERVAL, the block issues an internal TC read at lowest priority. No ack, rd_data unchanged.
  - On completion, if the read value != tc_poll: update tc_poll and pulse tc_change.
- Undefined: tc_poll=0 and tc_change=0 constantly; no internal requests.

Test Plan:
- CLK_DIV=2 with a behavioural nibble-port slave; wrd_req with wrd_data=0xA5.
  -> Driven nibbles are 0x2, 0xA, 0x5, then oe=0.
  -> Slave RD=0xA5; wrd_ack pulses 17 clks after grant.
- Slave TD=0x3C; rtd_req.
  -> SEL nibble is 0x0; rd_data=0x3C at the rtd_ack pulse; pi_data_oe=0 during NIB_HI, NIB_LO and TAIL.
- wrc, wrd, rtc and rtd requests raised in the same cycle, with slave TC=0x81 and TD=0x7E.
  -> Completion order is wrc, wrd, rtc (rd_data=0x81), rtd (rd_data=0x7E).
  -> Exactly 1 IDLE clk between transactions.
- Assert reset during NIB_HI of a write of 0xFF.
  -> No ack; pi_reset=1 for RESET_CYCLES periods.
  -> A following write of 0x12 lands correctly in the slave (RD=0x12).
- TIPI_PI_AUTO_POLL_EN defined, POLL_INTERVAL=16, slave TC changes 0x00 to 0x55.
  -> Auto-read occurs; tc_poll=0x55 and tc_change pulses once.
  -> A repeat poll at the same TC value gives no pulse.
- wrd_req dropped 1 clk after grant.
  -> Transaction completes and wrd_ack still pulses once.

Source files
------------

// File: rtl/tipi_pi_bus_master.sv
// MCU-side sequencer for the TIPI 4-bit nibble bus: bus clock/reset generation,
// fixed-priority arbitration of RD/RC writes and TD/TC reads. Optional TC auto-poll: TIPI_PI_AUTO_POLL_EN.
module tipi_pi_bus_master #(
  parameter int CLK_DIV       = 4,
  parameter int RESET_CYCLES  = 2,
  parameter int POLL_INTERVAL = 1024
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pi_clk,
  output logic       pi_reset,
  output logic [3:0] pi_data_o,
  output logic       pi_data_oe,
  input  logic [3:0] pi_data_i,
  input  logic       wrd_req,
  input  logic [7:0] wrd_data,
  output logic       wrd_ack,
  input  logic       wrc_req,
  input  logic [7:0] wrc_data,
  output logic       wrc_ack,
  input  logic       rtd_req,
  output logic       rtd_ack,
  input  logic       rtc_req,
  output logic       rtc_ack,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic [7:0] tc_poll,
  output logic       tc_change
);

  typedef enum logic [2:0] {BUS_RST, IDLE, SEL, NIB_HI, NIB_LO, TAIL} state_t;

  localparam logic [8:0]  DIV_LAST = 9'(2 * CLK_DIV - 1);
  localparam logic [8:0]  DIV_HALF = 9'(CLK_DIV);
  localparam logic [8:0]  DIV_SMP  = 9'(CLK_DIV - 1);
  localparam logic [15:0] RST_LAST = 16'(RESET_CYCLES - 1);

  state_t      state, state_n;
  logic [8:0]  div_cnt;
  logic [15:0] rst_cnt;
  logic [1:0]  gnt_code;
  logic        gnt_auto;
  logic [7:0]  wdata;
  logic [3:0]  rx_hi, rx_lo;
  logic        period_end, sample_pt, ext_req, poll_req, any_req, txn_done;
  logic [1:0]  arb_code;

  assign period_end = (div_cnt == DIV_LAST);
  assign sample_pt  = (div_cnt == DIV_SMP);
  assign ext_req    = wrc_req | wrd_req | rtc_req | rtd_req;
  assign any_req    = ext_req | poll_req;
  assign txn_done   = (state == TAIL) && period_end;

  // sel codes double as grant ids: TD=00, TC=01, RD=10, RC=11; auto-poll reads TC.
  always_comb begin
    if (wrc_req)      arb_code = 2'b11;
    else if (wrd_req) arb_code = 2'b10;
    else if (rtc_req) arb_code = 2'b01;
    else if (rtd_req) arb_code = 2'b00;
    else              arb_code = 2'b01;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= BUS_RST;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    pi_data_o  = 4'h0;
    pi_data_oe = 1'b0;
    pi_clk     = (div_cnt >= DIV_HALF);
    pi_reset   = (state == BUS_RST);
    busy       = (state != IDLE);
    case (state)
      BUS_RST: if (period_end && rst_cnt == RST_LAST) state_n = IDLE;
      IDLE:    if (any_req) state_n = SEL;
      SEL: begin
        pi_data_oe = 1'b1;
        pi_data_o  = {2'b00, gnt_code};
        if (period_end) state_n = NIB_HI;
      end
      NIB_HI: begin
        pi_data_oe = gnt_code[1];
        pi_data_o  = gnt_code[1] ? wdata[7:4] : 4'h0;
        if (period_end) state_n = NIB_LO;
      end
      NIB_LO: begin
        pi_data_oe = gnt_code[1];
        pi_data_o  = gnt_code[1] ? wdata[3:0] : 4'h0;
        if (period_end) state_n = TAIL;
      end
      TAIL:    if (period_end) state_n = IDLE;
      default: state_n = BUS_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt  <= '0;
      rst_cnt  <= '0;
      gnt_code <= 2'b00;
      gnt_auto <= 1'b0;
      wdata    <= 8'h00;
      rx_hi    <= 4'h0;
      rx_lo    <= 4'h0;
      rd_data  <= 8'h00;
      wrd_ack  <= 1'b0;
      wrc_ack  <= 1'b0;
      rtd_ack  <= 1'b0;
      rtc_ack  <= 1'b0;
    end else begin
      wrd_ack <= 1'b0;
      wrc_ack <= 1'b0;
      rtd_ack <= 1'b0;
      rtc_ack <= 1'b0;
      // IDLE parks the divider at 0 so a grant starts a clean low phase.
      div_cnt <= (state == IDLE || period_end) ? 9'd0 : div_cnt + 9'd1;
      if (state == BUS_RST && period_end) rst_cnt <= rst_cnt + 16'd1;
      if (state == IDLE && any_req) begin
        gnt_code <= arb_code;
        gnt_auto <= !ext_req;
        wdata    <= wrc_req ? wrc_data : wrd_data;
      end
      if (sample_pt && state == NIB_HI) rx_hi <= pi_data_i;
      if (sample_pt && state == NIB_LO) rx_lo <= pi_data_i;
      if (txn_done && !gnt_auto) begin
        case (gnt_code)
          2'b00:   rtd_ack <= 1'b1;
          2'b01:   rtc_ack <= 1'b1;
          2'b10:   wrd_ack <= 1'b1;
          default: wrc_ack <= 1'b1;
        endcase
        if (!gnt_code[1]) rd_data <= {rx_hi, rx_lo};
      end
    end
  end

`ifdef TIPI_PI_AUTO_POLL_EN
  localparam int PW = $clog2(POLL_INTERVAL + 1);
  logic [PW-1:0] idle_cnt;

  assign poll_req = (state == IDLE) && (idle_cnt == PW'(POLL_INTERVAL));

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt  <= '0;
      tc_poll   <= 8'h00;
      tc_change <= 1'b0;
    end else begin
      tc_change <= 1'b0;
      if (state != IDLE) idle_cnt <= '0;
      else if (!ext_req && idle_cnt != PW'(POLL_INTERVAL)) idle_cnt <= idle_cnt + 1'b1;
      if (txn_done && gnt_auto && {rx_hi, rx_lo} != tc_poll) begin
        tc_poll   <= {rx_hi, rx_lo};
        tc_change <= 1'b1;
      end
    end
  end
`else
  assign poll_req  = 1'b0;
  assign tc_poll   = 8'h00;
  assign tc_change = 1'b0;
`endif

endmodule

// File: tb/tb_tipi_pi_bus_master.sv
// Directed bench for tipi_pi_bus_master (CLK_DIV=2, RESET_CYCLES=2, POLL_INTERVAL=16)
// with a behavioural nibble-port slave holding TD/TC/RD/RC.
module tb_tipi_pi_bus_master;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pi_clk, pi_reset, pi_data_oe;
  logic [3:0] pi_data_o, pi_data_i;
  logic       wrd_req, wrc_req, rtd_req, rtc_req;
  logic [7:0] wrd_data, wrc_data;
  logic       wrd_ack, wrc_ack, rtd_ack, rtc_ack;
  logic [7:0] rd_data, tc_poll;
  logic       busy, tc_change;

  always #5 clk = ~clk;

  tipi_pi_bus_master #(.CLK_DIV(2), .RESET_CYCLES(2), .POLL_INTERVAL(16)) dut (
    .clk(clk), .reset(reset), .pi_clk(pi_clk), .pi_reset(pi_reset),
    .pi_data_o(pi_data_o), .pi_data_oe(pi_data_oe), .pi_data_i(pi_data_i),
    .wrd_req(wrd_req), .wrd_data(wrd_data), .wrd_ack(wrd_ack),
    .wrc_req(wrc_req), .wrc_data(wrc_data), .wrc_ack(wrc_ack),
    .rtd_req(rtd_req), .rtd_ack(rtd_ack), .rtc_req(rtc_req), .rtc_ack(rtc_ack),
    .rd_data(rd_data), .busy(busy), .tc_poll(tc_poll), .tc_change(tc_change)
  );

  // Slave: 4-count per transaction on pi_clk rising edges, cleared by pi_reset.
  logic [1:0] s_cnt, s_sel;
  logic [3:0] s_hi;
  logic [7:0] s_td, s_tc, s_rd, s_rc;

  always @(posedge pi_clk) begin
    if (pi_reset) begin
      s_cnt <= 2'd0;
    end else begin
      case (s_cnt)
        2'd0: begin
          s_sel     <= pi_data_o[1:0];
          pi_data_i <= pi_data_o[0] ? s_tc[7:4] : s_td[7:4];
        end
        2'd1: begin
          s_hi      <= pi_data_o;
          pi_data_i <= s_sel[0] ? s_tc[3:0] : s_td[3:0];
        end
        2'd2: if (s_sel[1]) begin
          if (s_sel[0]) s_rc <= {s_hi, pi_data_o};
          else          s_rd <= {s_hi, pi_data_o};
        end
        default: ;
      endcase
      s_cnt <= s_cnt + 2'd1;
    end
  end

  logic [4:0] nib_q[$];
  always @(posedge pi_clk) if (!pi_reset) nib_q.push_back({pi_data_oe, pi_data_o});

  int total = 0;
  int bad = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic ack_of(input int id);
    case (id)
      0:       return rtd_ack;
      1:       return rtc_ack;
      2:       return wrd_ack;
      default: return wrc_ack;
    endcase
  endfunction

  task automatic set_req(input int id, input logic v);
    case (id)
      0:       rtd_req = v;
      1:       rtc_req = v;
      2:       wrd_req = v;
      default: wrc_req = v;
    endcase
  endtask

  // Called at a negedge while idle; lat counts negedges from raise to first ack.
  task automatic do_txn(input int id, input logic [7:0] wd, input int drop_at,
                        output int lat, output int nack, output logic [7:0] rd);
    lat = -1; nack = 0; rd = 8'h00;
    if (id == 2) wrd_data = wd;
    if (id == 3) wrc_data = wd;
    set_req(id, 1'b1);
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == drop_at) set_req(id, 1'b0);
      if (ack_of(id)) begin
        nack++;
        if (lat < 0) begin lat = i; rd = rd_data; end
        set_req(id, 1'b0);
      end
      if (lat >= 0 && i >= lat + 3) break;
    end
    set_req(id, 1'b0);
  endtask

  task automatic count_rst(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (!pi_reset) break;
      n++;
      @(negedge clk);
    end
  endtask

  int lat, nack, n, idle_n, pulses, acks;
  logic [7:0] rd;

  initial begin
    wrd_req = 0; wrc_req = 0; rtd_req = 0; rtc_req = 0;
    wrd_data = 8'h00; wrc_data = 8'h00;
    s_td = 8'h3C; s_tc = 8'h81;
    repeat (3) @(negedge clk);
    check("rst_pi_clk", pi_clk, 0);
    check("rst_pi_reset", pi_reset, 1);
    check("rst_oe_data", {pi_data_oe, pi_data_o}, 0);
    check("rst_busy", busy, 1);
    check("rst_acks_rd", {wrd_ack, wrc_ack, rtd_ack, rtc_ack, rd_data}, 0);
    check("rst_poll", {tc_poll, tc_change}, 0);
    reset = 0;
    count_rst(n);
    check("bus_rst_len", n, 8);
    check("idle_busy", busy, 0);

    // Write RD=0xA5.
    nib_q.delete();
    do_txn(2, 8'hA5, 0, lat, nack, rd);
    check("wrd_lat", lat, 17);
    check("wrd_nack", nack, 1);
    check("wrd_nibs", nib_q.size(), 4);
    if (nib_q.size() == 4) begin
      check("wrd_sel", nib_q[0], 5'h12);
      check("wrd_hi", nib_q[1], 5'h1A);
      check("wrd_lo", nib_q[2], 5'h15);
      check("wrd_tail_oe", nib_q[3][4], 0);
    end
    check("slave_rd_a5", s_rd, 8'hA5);

    // Read TD=0x3C.
    nib_q.delete();
    do_txn(0, 8'h00, 0, lat, nack, rd);
    check("rtd_lat", lat, 17);
    check("rtd_data", rd, 8'h3C);
    check("rtd_nibs", nib_q.size(), 4);
    if (nib_q.size() == 4) begin
      check("rtd_sel", nib_q[0], 5'h10);
      check("rtd_oe_off", {nib_q[1][4], nib_q[2][4], nib_q[3][4]}, 0);
    end

    // All four at once: wrc > wrd > rtc > rtd, back to back.
    s_tc = 8'h81; s_td = 8'h7E;
    wrc_data = 8'h33; wrd_data = 8'h44;
    exp_q = '{{8'd3, 8'd17}, {8'd2, 8'd34}, {8'd1, 8'd51}, {8'd0, 8'd68}};
    wrc_req = 1; wrd_req = 1; rtc_req = 1; rtd_req = 1;
    idle_n = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (!busy) idle_n++;
      for (int id = 3; id >= 0; id--) begin
        if (ack_of(id)) begin
          set_req(id, 1'b0);
          if (exp_q.size() == 0) check("prio_extra_ack", id, 99);
          else check("prio_order", {8'(id), 8'(i)}, exp_q.pop_front());
          if (id == 1) check("prio_rtc_data", rd_data, 8'h81);
          if (id == 0) check("prio_rtd_data", rd_data, 8'h7E);
        end
      end
      if (exp_q.size() == 0) break;
    end
    check("prio_missing", exp_q.size(), 0);
    check("prio_idle_clks", idle_n, 4);
    check("prio_rc", s_rc, 8'h33);
    check("prio_rd", s_rd, 8'h44);
    wrc_req = 0; wrd_req = 0; rtc_req = 0; rtd_req = 0;

    // Reset during NIB_HI of a 0xFF write.
    acks = 0;
    wrd_data = 8'hFF; wrd_req = 1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (wrd_ack) acks++;
    end
    reset = 1; wrd_req = 0;
    repeat (2) begin
      @(negedge clk);
      if (wrd_ack) acks++;
    end
    reset = 0;
    count_rst(n);
    check("abort_rst_len", n, 8);
    check("abort_no_ack", acks, 0);
    check("abort_rd_kept", s_rd, 8'h44);
    check("abort_rd_data", rd_data, 8'h00);
    do_txn(2, 8'h12, 0, lat, nack, rd);
    check("after_abort_lat", lat, 17);
    check("after_abort_rd", s_rd, 8'h12);

    // Request dropped one clk after grant.
    do_txn(2, 8'h6B, 1, lat, nack, rd);
    check("drop_lat", lat, 17);
    check("drop_nack", nack, 1);
    check("drop_rd", s_rd, 8'h6B);

`ifdef TIPI_PI_AUTO_POLL_EN
    s_tc = 8'h00;
    pulses = 0; acks = 0;
    repeat (120) begin
      @(negedge clk);
      if (tc_change) pulses++;
      if (rtc_ack) acks++;
    end
    check("poll_same_zero", pulses, 0);
    s_tc = 8'h55;
    repeat (150) begin
      @(negedge clk);
      if (tc_change) pulses++;
      if (rtc_ack) acks++;
    end
    check("poll_pulses", pulses, 1);
    check("poll_value", tc_poll, 8'h55);
    check("poll_no_ack", acks, 0);
    check("poll_rd_kept", rd_data, 8'h00);
`else
    s_tc = 8'h55;
    pulses = 0; n = 0;
    repeat (120) begin
      @(negedge clk);
      if (tc_change) pulses++;
      if (busy) n++;
    end
    check("nopoll_pulses", pulses, 0);
    check("nopoll_value", tc_poll, 8'h00);
    check("nopoll_busy", n, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
